// File: rtl/quad_debounce.sv
// Per-channel stability filter for quadrature phases A/B, with same-edge update flagging.
// Define QDEB_GLITCH_CNT_EN to add the saturating rejected-glitch counter output o_glitch_cnt.
module quad_debounce #(
  parameter int unsigned p_STABLE_CYCLES = 1000,
  parameter int unsigned p_CNT_WIDTH     = 10,
  parameter logic [1:0]  p_RESET_VAL     = 2'b11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_phase_a,
  input  logic       i_phase_b,
  output logic       o_phase_a,
  output logic       o_phase_b,
  output logic       o_change,
  output logic       o_double
`ifdef QDEB_GLITCH_CNT_EN
  ,
  output logic [7:0] o_glitch_cnt
`endif
);

  localparam logic [p_CNT_WIDTH-1:0] LAST = p_CNT_WIDTH'(p_STABLE_CYCLES - 1);
  localparam logic [p_CNT_WIDTH-1:0] ONE  = p_CNT_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

  state_t                 state_q [2];
  state_t                 state_d [2];
  logic [p_CNT_WIDTH-1:0] cnt_q   [2];
  logic [p_CNT_WIDTH-1:0] cnt_d   [2];
  logic [1:0]             raw;
  logic [1:0]             out_q;
  logic [1:0]             out_d;
  logic [1:0]             upd;

  // Bit 1 carries phase A, bit 0 phase B, matching the {a,b} order of p_RESET_VAL.
  assign raw       = {i_phase_a, i_phase_b};
  assign o_phase_a = out_q[1];
  assign o_phase_b = out_q[0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_q    <= p_RESET_VAL;
      o_change <= 1'b0;
      o_double <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      out_q    <= out_d;
      o_change <= |upd;
      o_double <= &upd;
    end
  end

  always_comb begin
    out_d = out_q;
    upd   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (raw[i] != out_q[i]) begin
            // A one-cycle filter accepts on the first differing sample, so no PEND visit.
            if (p_STABLE_CYCLES == 1) begin
              out_d[i] = raw[i];
              upd[i]   = 1'b1;
            end else begin
              state_d[i] = PEND;
              cnt_d[i]   = ONE;
            end
          end
        end
        PEND: begin
          if (raw[i] == out_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LAST) begin
            out_d[i]   = raw[i];
            upd[i]     = 1'b1;
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef QDEB_GLITCH_CNT_EN
  logic [1:0] abort;
  logic [1:0] n_abort;
  logic [8:0] glitch_sum;

  assign abort[1]   = (state_q[1] == PEND) && (raw[1] == out_q[1]);
  assign abort[0]   = (state_q[0] == PEND) && (raw[0] == out_q[0]);
  assign n_abort    = {1'b0, abort[1]} + {1'b0, abort[0]};
  assign glitch_sum = {1'b0, o_glitch_cnt} + {7'b0, n_abort};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      o_glitch_cnt <= '0;
    end else begin
      o_glitch_cnt <= glitch_sum[8] ? 8'hFF : glitch_sum[7:0];
    end
  end
`endif

endmodule

// File: tb/tb_quad_debounce.sv
// Scoreboard bench for quad_debounce: filter length 4 on dut0, filter length 1 on dut1.
// Expected {a,b,change,double} vectors are queued as stimulus is applied and checked after each edge.
module tb_quad_debounce;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic a   = 1'b0;
  logic b   = 1'b0;

  logic a0, b0, chg0, dbl0;
  logic a1, b1, chg1, dbl1;
`ifdef QDEB_GLITCH_CNT_EN
  logic [7:0] gc0, gc1;
`endif

  int vectors = 0;
  int fails   = 0;
  logic [3:0] exp_q [$];

  always #5 CLK = ~CLK;

  quad_debounce #(
    .p_STABLE_CYCLES(4),
    .p_CNT_WIDTH    (3),
    .p_RESET_VAL    (2'b11)
  ) dut0 (
    .CLK      (CLK),
    .RST      (RST),
    .i_phase_a(a),
    .i_phase_b(b),
    .o_phase_a(a0),
    .o_phase_b(b0),
    .o_change (chg0),
    .o_double (dbl0)
`ifdef QDEB_GLITCH_CNT_EN
    ,
    .o_glitch_cnt(gc0)
`endif
  );

  quad_debounce #(
    .p_STABLE_CYCLES(1),
    .p_CNT_WIDTH    (1),
    .p_RESET_VAL    (2'b11)
  ) dut1 (
    .CLK      (CLK),
    .RST      (RST),
    .i_phase_a(a),
    .i_phase_b(b),
    .o_phase_a(a1),
    .o_phase_b(b1),
    .o_change (chg1),
    .o_double (dbl1)
`ifdef QDEB_GLITCH_CNT_EN
    ,
    .o_glitch_cnt(gc1)
`endif
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [3:0] e, got;
    RST = 1'b1; a = 1'b0; b = 1'b0;
    repeat (2) tick();
    got = {a0, b0, chg0, dbl0};
    vectors++;
    if (got !== 4'b1100) begin
      fails++;
      $display("FAIL reset_state got=%b exp=%b", got, 4'b1100);
    end
`ifdef QDEB_GLITCH_CNT_EN
    vectors++;
    if (gc0 !== 8'd0) begin
      fails++;
      $display("FAIL reset_glitch got=%0d exp=0", gc0);
    end
`endif
    RST = 1'b0; b = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({(k < 4), 1'b1, (k == 4), 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL settle_a edge=%0d got=%b exp=%b", k, got, e);
      end
    end
    b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({1'b0, (k < 4), (k == 4), 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL settle_b edge=%0d got=%b exp=%b", k, got, e);
      end
    end
    exp_q.push_back(4'b0000);
    tick();
    e = exp_q.pop_front();
    got = {a0, b0, chg0, dbl0};
    vectors++;
    if (got !== e) begin
      fails++;
      $display("FAIL change_one_cycle got=%b exp=%b", got, e);
    end
  endtask

  task automatic test_double(input logic lvl);
    logic [3:0] e, got;
    a = lvl; b = lvl;
    for (int k = 1; k <= 5; k++) begin
      if (k < 4)       exp_q.push_back({~lvl, ~lvl, 2'b00});
      else if (k == 4) exp_q.push_back({lvl, lvl, 2'b11});
      else             exp_q.push_back({lvl, lvl, 2'b00});
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL double_%0b edge=%0d got=%b exp=%b", lvl, k, got, e);
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] e, got;
    for (int k = 1; k <= 5; k++) begin
      a = (k <= 3) ? 1'b0 : 1'b1;
      exp_q.push_back(4'b1100);
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL glitch edge=%0d got=%b exp=%b", k, got, e);
      end
    end
`ifdef QDEB_GLITCH_CNT_EN
    vectors++;
    if (gc0 !== 8'd1) begin
      fails++;
      $display("FAIL glitch_count got=%0d exp=1", gc0);
    end
`endif
  endtask

  task automatic test_glitch_sat();
    logic [3:0] got;
    int bad = 0;
    for (int g = 0; g < 300; g++) begin
      for (int k = 0; k < 3; k++) begin
        a = (k < 2) ? 1'b0 : 1'b1;
        tick();
        if ({a0, b0, chg0, dbl0} !== 4'b1100) bad++;
      end
    end
    got = {a0, b0, chg0, dbl0};
    vectors++;
    if (bad != 0) begin
      fails++;
      $display("FAIL glitch_train bad_cycles=%0d exp=0 last=%b", bad, got);
    end
`ifdef QDEB_GLITCH_CNT_EN
    vectors++;
    if (gc0 !== 8'hFF) begin
      fails++;
      $display("FAIL glitch_saturate got=%0d exp=255", gc0);
    end
`endif
  endtask

  task automatic test_toggle();
    logic [3:0] e, got;
    for (int k = 0; k < 10; k++) begin
      a = k[0];
      exp_q.push_back(4'b1100);
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL toggle edge=%0d got=%b exp=%b", k, got, e);
      end
    end
    a = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [3:0] e, got;
    // outputs are 00 here; start a pending rise and reset asynchronously mid-cycle
    a = 1'b1; b = 1'b1;
    repeat (2) tick();
    RST = 1'b1;
    #1;
    got = {a0, b0, chg0, dbl0};
    vectors++;
    if (got !== 4'b1100) begin
      fails++;
      $display("FAIL async_reset got=%b exp=%b", got, 4'b1100);
    end
    tick();
    RST = 1'b0;
    a = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
`ifdef QDEB_GLITCH_CNT_EN
    vectors++;
    if (gc0 !== 8'd0) begin
      fails++;
      $display("FAIL reset_clears_glitch got=%0d exp=0", gc0);
    end
`endif
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back({(k < 4), 1'b1, (k == 4), 1'b0});
      tick();
      e = exp_q.pop_front();
      got = {a0, b0, chg0, dbl0};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL fresh_count edge=%0d got=%b exp=%b", k, got, e);
      end
    end
  endtask

  task automatic test_stable_one();
    logic [3:0] e, got;
    logic pa, pb, na, nb;
    RST = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    RST = 1'b0;
    pa = 1'b1; pb = 1'b1;
    for (int k = 0; k < 24; k++) begin
      na = 1'($urandom_range(0, 1));
      nb = 1'($urandom_range(0, 1));
      if (k == 0) begin na = 1'b0; nb = 1'b0; end
      a = na; b = nb;
      exp_q.push_back({na, nb, (na != pa) || (nb != pb), (na != pa) && (nb != pb)});
      pa = na; pb = nb;
      tick();
      e = exp_q.pop_front();
      got = {a1, b1, chg1, dbl1};
      vectors++;
      if (got !== e) begin
        fails++;
        $display("FAIL stable_one edge=%0d got=%b exp=%b", k, got, e);
      end
    end
`ifdef QDEB_GLITCH_CNT_EN
    vectors++;
    if (gc1 !== 8'd0) begin
      fails++;
      $display("FAIL stable_one_glitch got=%0d exp=0", gc1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_double(1'b1);
    test_glitch();
    test_glitch_sat();
    test_toggle();
    test_double(1'b0);
    test_reset_mid();
    test_stable_one();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
